// File: rtl/blake2_stream_ctrl.sv
// Streams message words into BLAKE2 engine blocks and sequences the
// init/next/final pulses, then holds the captured digest until it is consumed.
module blake2_stream_ctrl #(
    parameter int BLOCK_WIDTH   = 512,
    parameter int WORD_WIDTH    = 32,
    parameter int DATA_LENGTH   = 64,
    parameter int DIGEST_LENGTH = 88
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [WORD_WIDTH-1:0]              in_data,
    input  logic [$clog2(WORD_WIDTH/8):0]      in_nbytes,
    input  logic                               in_last,
    output logic                               eng_init,
    output logic                               eng_next,
    output logic                               eng_final,
    output logic [BLOCK_WIDTH-1:0]             eng_block,
    output logic [DATA_LENGTH-1:0]             eng_length,
    input  logic                               eng_hash_ready,
    input  logic                               eng_digest_valid,
    input  logic [DIGEST_LENGTH-1:0]           eng_digest,
    output logic                               dig_valid,
    input  logic                               dig_ready,
    output logic [DIGEST_LENGTH-1:0]           dig_data,
    output logic                               busy
);

    localparam int WORDS  = BLOCK_WIDTH / WORD_WIDTH;
    localparam int WBYTES = WORD_WIDTH / 8;
    localparam int IW     = $clog2(WORDS + 1);

    typedef enum logic [2:0] {IDLE, INIT, FILL, ISSUE, WAIT, DONE} state_t;

    state_t                     state_q;
    logic [BLOCK_WIDTH-1:0]     block_q;
    logic [DATA_LENGTH-1:0]     len_q;
    logic [IW-1:0]              idx_q;
    logic                       final_q;
    logic                       wait_final_q;
    logic                       guard_q;
    logic                       fresh_q;
    logic                       init_q;
    logic                       next_q;
    logic                       fin_q;
    logic                       dig_valid_q;
    logic [DIGEST_LENGTH-1:0]   dig_q;

    logic                       full;
    logic                       accept;
    logic [WORD_WIDTH-1:0]      masked;
    logic [BLOCK_WIDTH-1:0]     block_d;

    assign full       = (idx_q == IW'(WORDS));
    assign in_ready   = (state_q == FILL) && !full;
    assign accept     = in_valid && in_ready;
    assign busy       = (state_q != IDLE);
    assign eng_init   = init_q;
    assign eng_next   = next_q;
    assign eng_final  = fin_q;
    assign eng_block  = block_q;
    assign eng_length = len_q;
    assign dig_valid  = dig_valid_q;
    assign dig_data   = dig_q;

    always_comb begin
        masked = '0;
        for (int unsigned b = 0; b < WBYTES; b++) begin
            if (b < 32'(in_nbytes)) masked[b*8 +: 8] = in_data[b*8 +: 8];
        end
        // The previous block is cleared lazily on the first write so it stays
        // visible to the engine until new data actually arrives.
        block_d = fresh_q ? '0 : block_q;
        if (!full) block_d[int'(idx_q)*WORD_WIDTH +: WORD_WIDTH] = masked;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            block_q      <= '0;
            len_q        <= '0;
            idx_q        <= '0;
            final_q      <= 1'b0;
            wait_final_q <= 1'b0;
            guard_q      <= 1'b0;
            fresh_q      <= 1'b0;
            init_q       <= 1'b0;
            next_q       <= 1'b0;
            fin_q        <= 1'b0;
            dig_valid_q  <= 1'b0;
            dig_q        <= '0;
        end else begin
            init_q <= 1'b0;
            next_q <= 1'b0;
            fin_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid && eng_hash_ready) begin
                        init_q  <= 1'b1;
                        block_q <= '0;
                        len_q   <= '0;
                        idx_q   <= '0;
                        fresh_q <= 1'b0;
                        state_q <= INIT;
                    end
                end
                INIT: begin
                    guard_q      <= 1'b1;
                    wait_final_q <= 1'b0;
                    state_q      <= WAIT;
                end
                FILL: begin
                    if (accept) begin
                        block_q <= block_d;
                        fresh_q <= 1'b0;
                        idx_q   <= idx_q + IW'(1);
                        len_q   <= len_q + DATA_LENGTH'(in_nbytes);
                        if (in_last) begin
                            final_q <= 1'b1;
                            state_q <= ISSUE;
                        end
                    end else if (full && in_valid) begin
                        final_q <= 1'b0;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (eng_hash_ready) begin
                        next_q       <= !final_q;
                        fin_q        <= final_q;
                        wait_final_q <= final_q;
                        guard_q      <= 1'b1;
                        state_q      <= WAIT;
                    end
                end
                WAIT: begin
                    // Pulse cycle, then one guard cycle, before trusting eng_hash_ready.
                    if (next_q || fin_q) begin
                        guard_q <= 1'b1;
                    end else if (guard_q) begin
                        guard_q <= 1'b0;
                    end else if (eng_hash_ready && (!wait_final_q || eng_digest_valid)) begin
                        if (wait_final_q) begin
                            dig_q       <= eng_digest;
                            dig_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            idx_q   <= '0;
                            fresh_q <= 1'b1;
                            state_q <= FILL;
                        end
                    end
                end
                DONE: begin
                    if (dig_ready) begin
                        dig_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
